// File: rtl/bn_coef_loader.sv
// Double-buffered batch-norm coefficient loader: streams per-channel a/b into a shadow bank,
// commits to the active bank on swap_req. Optional macro BN_COEF_LAST_CHECK_EN enables coef_last framing checks.
module bn_coef_loader #(
    parameter int NO_CH = 10,
    parameter int BW_A  = 12,
    parameter int BW_B  = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        coef_vld,
    output logic                        coef_rdy,
    input  logic [BW_A-1:0]             coef_a,
    input  logic [BW_B-1:0]             coef_b,
    input  logic                        coef_last,
    input  logic                        swap_req,
    output logic                        swap_ack,
    output logic [NO_CH-1:0][BW_A-1:0]  a,
    output logic [NO_CH-1:0][BW_B-1:0]  b,
    output logic                        coef_loaded,
    output logic                        err_len
);
    localparam int IW = (NO_CH > 1) ? $clog2(NO_CH) : 1;

    logic [IW-1:0]              wr_idx_q, wr_idx_d;
    logic                       shadow_full_q, shadow_full_d;
    logic [NO_CH-1:0][BW_A-1:0] sh_a_q, a_q;
    logic [NO_CH-1:0][BW_B-1:0] sh_b_q, b_q;
    logic                       loaded_q, ack_q;

    logic accept, last_idx, set_done, frame_err, commit;

    assign coef_rdy = !shadow_full_q;
    assign accept   = coef_vld & coef_rdy;
    assign last_idx = (wr_idx_q == IW'(NO_CH - 1));
    assign commit   = shadow_full_q & swap_req;

`ifdef BN_COEF_LAST_CHECK_EN
    logic err_q;
    // A set only completes when the producer's last marker agrees with our count.
    assign set_done  = accept & last_idx & coef_last;
    assign frame_err = accept & (coef_last != last_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           err_q <= 1'b0;
        else if (frame_err) err_q <= 1'b1;
    end
    assign err_len = err_q;
`else
    logic unused_last;
    assign unused_last = coef_last;
    assign set_done    = accept & last_idx;
    assign frame_err   = 1'b0;
    assign err_len     = 1'b0;
`endif

    always_comb begin
        wr_idx_d      = wr_idx_q;
        shadow_full_d = shadow_full_q;
        if (accept) begin
            if (set_done || frame_err) wr_idx_d = '0;
            else                       wr_idx_d = wr_idx_q + IW'(1);
        end
        if (commit)        shadow_full_d = 1'b0;
        else if (set_done) shadow_full_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx_q      <= '0;
            shadow_full_q <= 1'b0;
            loaded_q      <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            wr_idx_q      <= wr_idx_d;
            shadow_full_q <= shadow_full_d;
            ack_q         <= commit;
            if (commit) loaded_q <= 1'b1;
        end
    end

    // Beats of a discarded partial set may land here; they are overwritten before any commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_a_q <= '0;
            sh_b_q <= '0;
        end else begin
            for (int ch = 0; ch < NO_CH; ch++) begin
                if (accept && wr_idx_q == IW'(ch)) begin
                    sh_a_q[ch] <= coef_a;
                    sh_b_q[ch] <= coef_b;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (commit) begin
            a_q <= sh_a_q;
            b_q <= sh_b_q;
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign swap_ack    = ack_q;
    assign coef_loaded = loaded_q;
endmodule
